// File: rtl/hb1_interp_filter.sv
// 2x halfband interpolator, 7-tap polyphase; HB_INTERP_SAT_EN saturates the even phase, otherwise it wraps.
// Even sample 2 clk after input strobe, odd 1 clk after 2x strobe; no backpressure, misuse sets sticky phase_err.
module hb1_interp_filter #(
   parameter int DW = 35,
   parameter int COEF_W = 31,
   parameter logic signed [COEF_W-1:0] C0 = 31'sd54357298,
   parameter logic signed [COEF_W-1:0] C1 = 31'sd316817548,
   parameter int FRAC = 30
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clk_vld_in,
   input  logic          clk_vld_2x,
   input  logic [DW-1:0] dat_in,
   output logic          clk_vld_out,
   output logic [DW-1:0] dat_out,
   output logic          phase_err
);
   localparam int PW = DW + COEF_W + 2;

   typedef enum logic [1:0] {S_WAIT, S_A, S_B} state_t;

   state_t               state_q, state_d;
   logic signed [DW-1:0] d0_q, d1_q, d2_q, d3_q;
   logic signed [DW-1:0] d0_d, d1_d, d2_d, d3_d;
   logic [DW-1:0]        dat_out_q, dat_out_d;
   logic                 vld_q, vld_d;
   logic                 err_q, err_d;

   logic signed [DW:0]   sum_03, sum_12;
   logic signed [PW-1:0] sum_03_x, sum_12_x, c0_x, c1_x, acc, acc_sh;
   logic [DW-1:0]        a_val;
   logic                 accept;

   // Symmetric taps share one multiplier each after the pre-add.
   always_comb begin
      sum_03   = {d0_q[DW-1], d0_q} + {d3_q[DW-1], d3_q};
      sum_12   = {d1_q[DW-1], d1_q} + {d2_q[DW-1], d2_q};
      sum_03_x = {{(PW-DW-1){sum_03[DW]}}, sum_03};
      sum_12_x = {{(PW-DW-1){sum_12[DW]}}, sum_12};
      c0_x     = {{(PW-COEF_W){C0[COEF_W-1]}}, C0};
      c1_x     = {{(PW-COEF_W){C1[COEF_W-1]}}, C1};
      acc      = c1_x * sum_12_x - c0_x * sum_03_x;
      acc_sh   = acc >>> (FRAC - 1);
`ifdef HB_INTERP_SAT_EN
      if ((&acc_sh[PW-1:DW-1]) || !(|acc_sh[PW-1:DW-1])) begin
         a_val = acc_sh[DW-1:0];
      end else if (acc_sh[PW-1]) begin
         a_val = {1'b1, {(DW-1){1'b0}}};
      end else begin
         a_val = {1'b0, {(DW-1){1'b1}}};
      end
`else
      a_val = acc_sh[DW-1:0];
`endif
   end

`ifndef HB_INTERP_SAT_EN
   logic unused_acc_hi;
   assign unused_acc_hi = ^acc_sh[PW-1:DW];
`endif

   assign accept = clk_vld_in & clk_vld_2x;

   always_comb begin
      state_d   = state_q;
      d0_d      = d0_q;
      d1_d      = d1_q;
      d2_d      = d2_q;
      d3_d      = d3_q;
      dat_out_d = dat_out_q;
      vld_d     = 1'b0;
      err_d     = err_q;

      if (clk_vld_in && !clk_vld_2x) begin
         err_d = 1'b1;
      end

      case (state_q)
         S_WAIT: begin
            if (accept) begin
               {d3_d, d2_d, d1_d, d0_d} = {d2_q, d1_q, d0_q, dat_in};
               state_d = S_A;
            end
         end
         S_A: begin
            dat_out_d = a_val;
            vld_d     = 1'b1;
            state_d   = S_B;
            if (clk_vld_in) begin
               err_d = 1'b1;
            end
         end
         S_B: begin
            // A new sample arriving before the odd slot forfeits that odd output.
            if (accept) begin
               {d3_d, d2_d, d1_d, d0_d} = {d2_q, d1_q, d0_q, dat_in};
               err_d   = 1'b1;
               state_d = S_A;
            end else if (clk_vld_2x) begin
               dat_out_d = d1_q;
               vld_d     = 1'b1;
               state_d   = S_WAIT;
            end
         end
         default: state_d = S_WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_WAIT;
         d0_q      <= '0;
         d1_q      <= '0;
         d2_q      <= '0;
         d3_q      <= '0;
         dat_out_q <= '0;
         vld_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         d0_q      <= d0_d;
         d1_q      <= d1_d;
         d2_q      <= d2_d;
         d3_q      <= d3_d;
         dat_out_q <= dat_out_d;
         vld_q     <= vld_d;
         err_q     <= err_d;
      end
   end

   assign clk_vld_out = vld_q;
   assign dat_out     = dat_out_q;
   assign phase_err   = err_q;
endmodule
